// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and case-folding helper for the UART command decoder.
package uart_cmd_pkg;

   localparam int BYTE_W = 8;

   localparam logic [7:0] CH_R   = 8'h52;
   localparam logic [7:0] CH_S   = 8'h53;
   localparam logic [7:0] CH_C   = 8'h43;
   localparam logic [7:0] CH_L   = 8'h4C;
   localparam logic [7:0] CH_U   = 8'h55;
   localparam logic [7:0] CH_D   = 8'h44;
   localparam logic [7:0] CH_M   = 8'h4D;
   localparam logic [7:0] CH_NAK = 8'h3F;

   localparam logic MODE_STOPWATCH = 1'b0;
   localparam logic MODE_WATCH     = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      ACK    = 2'd2
   } cmd_state_t;

   // Lower-case ASCII letters map onto their upper-case commands.
   function automatic logic [7:0] fold_case(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Byte FIFO with first-word fall-through head; pointers carry an extra wrap bit.
module cmd_fifo
   import uart_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [BYTE_W-1:0] mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage needs no reset: contents are meaningless while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Turns received UART bytes into one-cycle control strobes and an ASCII acknowledgement,
// tracking the stopwatch/watch mode toggled by 'M'.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter bit ECHO_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              o_uart_start,
   output logic              o_uart_stop,
   output logic              o_uart_clear,
   output logic              o_uart_left,
   output logic              o_uart_right,
   output logic              o_uart_up,
   output logic              o_uart_down,
   output logic              o_mode,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              o_drop,
   output cmd_state_t        fsm_state
);

   cmd_state_t        state;
   cmd_state_t        state_nxt;
   logic [BYTE_W-1:0] cmd_reg;
   logic [BYTE_W-1:0] ack_byte;
   logic [BYTE_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              hit_start, hit_stop, hit_clear;
   logic              hit_left, hit_right, hit_up, hit_down;
   logic              in_decode;

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_valid),
      .pop   (fifo_pop),
      .din   (rx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A byte arriving while full is lost even if a pop frees a slot this cycle.
   assign o_drop    = rx_valid && fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign in_decode = (state == DECODE);
   assign fsm_state = state;

   // TX handshake: tx_valid is high throughout ACK with tx_data frozen; the byte is
   // taken in the cycle where tx_valid && tx_ready, and the FSM leaves ACK on that edge.
   assign tx_valid = (state == ACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cmd_reg <= '0;
         o_mode  <= MODE_STOPWATCH;
         tx_data <= '0;
      end else begin
         state <= state_nxt;
         if (fifo_pop) cmd_reg <= fold_case(fifo_dout);
         if (in_decode) begin
            tx_data <= ack_byte;
            if (cmd_reg == CH_M) o_mode <= ~o_mode;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = DECODE;
         DECODE:  state_nxt = ECHO_EN ? ACK : IDLE;
         ACK:     if (tx_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      hit_start = 1'b0;
      hit_stop  = 1'b0;
      hit_clear = 1'b0;
      hit_left  = 1'b0;
      hit_right = 1'b0;
      hit_up    = 1'b0;
      hit_down  = 1'b0;
      ack_byte  = CH_NAK;
      if (cmd_reg == CH_M) begin
         ack_byte = CH_M;
      end else if (o_mode == MODE_STOPWATCH) begin
         case (cmd_reg)
            CH_R:    begin hit_start = 1'b1; ack_byte = CH_R; end
            CH_S:    begin hit_stop  = 1'b1; ack_byte = CH_S; end
            CH_C:    begin hit_clear = 1'b1; ack_byte = CH_C; end
            default: ack_byte = CH_NAK;
         endcase
      end else begin
         case (cmd_reg)
            CH_L:    begin hit_left  = 1'b1; ack_byte = CH_L; end
            CH_R:    begin hit_right = 1'b1; ack_byte = CH_R; end
            CH_U:    begin hit_up    = 1'b1; ack_byte = CH_U; end
            CH_D:    begin hit_down  = 1'b1; ack_byte = CH_D; end
            default: ack_byte = CH_NAK;
         endcase
      end
   end

   // Strobes are qualified by DECODE so they vanish with an asynchronous reset.
   assign o_uart_start = in_decode && hit_start;
   assign o_uart_stop  = in_decode && hit_stop;
   assign o_uart_clear = in_decode && hit_clear;
   assign o_uart_left  = in_decode && hit_left;
   assign o_uart_right = in_decode && hit_right;
   assign o_uart_up    = in_decode && hit_up;
   assign o_uart_down  = in_decode && hit_down;

endmodule
